// File: rtl/cache_slot_allocator_if.sv
// Client-facing bundle of the cache slot allocator: allocation handshake,
// slot release, flush and occupancy status.
interface cache_slot_allocator_if #(
  parameter int unsigned SLOTS = 20,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned REQ   = 4
);
  logic [REQ-1:0]   alloc_req;
  logic [REQ-1:0]   alloc_gnt;
  logic [IDX_W-1:0] alloc_idx;
  logic             free_valid;
  logic [IDX_W-1:0] free_idx;
  logic             flush;
  logic [SLOTS-1:0] avail_mask;
  logic [IDX_W:0]   avail_count;
  logic             full;
  logic             err_free;

  // Client side: requests, releases and flush.
  modport master (
    output alloc_req, free_valid, free_idx, flush,
    input  alloc_gnt, alloc_idx, avail_mask, avail_count, full, err_free
  );

  // Allocator side.
  modport slave (
    input  alloc_req, free_valid, free_idx, flush,
    output alloc_gnt, alloc_idx, avail_mask, avail_count, full, err_free
  );
endinterface

// File: rtl/cache_slot_allocator.sv
// Cache slot allocator: owns slot occupancy, grants the lowest free slot to
// a round-robin winner each cycle, and accepts releases and a global flush.
module cache_slot_allocator #(
  parameter int unsigned SLOTS = 20,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned REQ   = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  cache_slot_allocator_if.slave bus
);
  localparam int unsigned RrW  = (REQ > 1) ? $clog2(REQ) : 1;
  localparam int unsigned CntW = IDX_W + 1;

  logic [SLOTS-1:0] avail_q, avail_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [RrW-1:0]   rr_q, rr_d;
  // The registered grant doubles as last_gnt: they are always equal.
  logic [REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             full_q, full_d;
  logic             err_q, err_d;

  logic [REQ-1:0]   eligible;
  logic             win_found;
  logic [RrW-1:0]   win_idx;
  logic             slot_found;
  logic [IDX_W-1:0] slot_idx;
  logic             free_ok;
  logic             do_grant;

  // A requester just granted is skipped for one edge so it can drop its request.
  assign eligible = bus.alloc_req & ~gnt_q;

  // Round-robin winner: first eligible requester starting at rr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < REQ; i++) begin
      if (!win_found && eligible[RrW'((32'(rr_q) + i) % REQ)]) begin
        win_found = 1'b1;
        win_idx   = RrW'((32'(rr_q) + i) % REQ);
      end
    end
  end

  // Lowest-indexed available slot from the pre-edge mask.
  always_comb begin
    slot_found = 1'b0;
    slot_idx   = '0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (!slot_found && avail_q[IDX_W'(s)]) begin
        slot_found = 1'b1;
        slot_idx   = IDX_W'(s);
      end
    end
  end

  // Next state: flush overrides; otherwise grant and release both apply,
  // and a slot freed this edge is only allocatable from the next one.
  always_comb begin
    free_ok  = bus.free_valid && (32'(bus.free_idx) < SLOTS) && !avail_q[bus.free_idx];
    do_grant = win_found && slot_found && (count_q != '0);
    avail_d  = avail_q;
    count_d  = count_q;
    rr_d     = rr_q;
    gnt_d    = '0;
    idx_d    = idx_q;
    err_d    = 1'b0;
    if (bus.flush) begin
      avail_d = '1;
      count_d = CntW'(SLOTS);
    end else begin
      if (do_grant) begin
        avail_d[slot_idx] = 1'b0;
        gnt_d[win_idx]    = 1'b1;
        idx_d             = slot_idx;
        rr_d              = RrW'((32'(win_idx) + 1) % REQ);
      end
      if (free_ok) begin
        avail_d[bus.free_idx] = 1'b1;
      end
      err_d   = bus.free_valid && !free_ok;
      count_d = count_q - CntW'(do_grant) + CntW'(free_ok);
    end
    full_d = (count_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_q <= '1;
      count_q <= CntW'(SLOTS);
      rr_q    <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      avail_q <= avail_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign bus.alloc_gnt   = gnt_q;
  assign bus.alloc_idx   = idx_q;
  assign bus.avail_mask  = avail_q;
  assign bus.avail_count = count_q;
  assign bus.full        = full_q;
  assign bus.err_free    = err_q;
endmodule

// File: doc/cache_slot_allocator.md
# cache_slot_allocator

Allocator that owns the occupancy state of a small cache slot pool. It tracks which slots are available, arbitrates allocation requests from several requesters round-robin, and hands each winner the lowest-indexed free slot. It also accepts slot releases and a global flush. It sits between the cache datapath clients (systolic-array feeders and drainers) and the slot storage, replacing ad-hoc free-slot scanning with one sequenced owner.

## Interface
Parameters:
- SLOTS, 20, number of cache slots.
- IDX_W, 5, slot index width; SLOTS <= 2**IDX_W.
- REQ, 4, number of requesters.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- alloc_req  input  REQ  level request per requester; held until granted.
- alloc_gnt  output  REQ  registered one-hot grant, one-cycle pulse.
- alloc_idx  output  IDX_W  slot index granted; valid only while alloc_gnt != 0.
- free_valid  input  1  release strobe, one slot per cycle.
- free_idx  input  IDX_W  slot to release.
- flush  input  1  return every slot to available.
- avail_mask  output  SLOTS  registered; bit i = 1 means slot i is available.
- avail_count  output  IDX_W+1  number of 1s in avail_mask.
- full  output  1  avail_count == 0.
- err_free  output  1  one-cycle pulse flagging an illegal release.

## Operation
- Registered state:
  - avail_mask.
  - avail_count.
  - rr_ptr, log2(REQ) bits.
  - last_gnt, REQ bits, a copy of alloc_gnt.
  - The output registers.
- Eligible requesters: alloc_req & ~last_gnt. A requester is ignored at the edge immediately after its grant, so it can drop its request in the cycle after it sees alloc_gnt without receiving a double grant.
- Arbitration at each edge, when no flush, any requester eligible, and avail_count > 0:
  - Winner k is the first eligible requester scanning rr_ptr, rr_ptr+1, ... modulo REQ.
  - Slot s is the lowest index with avail_mask[s] = 1, taken from the pre-edge mask.
  - Next state: alloc_gnt = one-hot(k), alloc_idx = s, avail_mask[s] = 0, rr_ptr = (k+1) mod REQ.
- No grant when avail_count == 0:
  - alloc_gnt = 0 and alloc_idx holds its previous value.
  - rr_ptr is unchanged.
  - Requests stay pending; nothing is dropped.
- Release: free_valid with free_idx < SLOTS and avail_mask[free_idx] == 0 sets that bit at the edge.
- Illegal release: free_valid with free_idx >= SLOTS, or with a slot that is already available, produces err_free = 1 for one cycle. No state change.
- Simultaneous allocate and release at the same edge:
  - Both take effect.
  - The freed slot is not visible to that edge's allocation; it is used from the next edge.
  - avail_count next = avail_count - granted + freed.
- Flush has priority over everything at its edge:
  - avail_mask = all ones, avail_count = SLOTS.
  - alloc_gnt = 0, last_gnt = 0, err_free = 0; free_valid is ignored.
  - rr_ptr is unchanged.
- full is registered from next avail_count, so it is never stale relative to avail_mask.
- Reset values while rst_n = 0, asynchronous:
  - avail_mask = all ones, avail_count = SLOTS, full = 0.
  - alloc_gnt = 0, alloc_idx = 0, last_gnt = 0.
  - rr_ptr = 0, err_free = 0.
- Reset mid-operation discards all pending grants and ownership; clients must re-request after reset.

## Timing
- Allocation latency: request sampled at edge E, so alloc_gnt/alloc_idx are high during cycle E..E+1. Minimum 1 cycle, no bubble for a single requester beyond the mandatory skip.
- Throughput:
  - At most one grant per cycle overall.
  - A single continuously-requesting requester gets a grant every other cycle.
  - Two or more requesters get a grant every cycle.
- Release latency: the slot appears in avail_mask the cycle after free_valid, and is allocatable from the following edge.
- err_free asserts the cycle after the offending free_valid.
- Fairness: with all REQ requesting continuously, grant order is rr_ptr, rr_ptr+1, ... and no requester waits more than REQ grants.

## Test plan
- Reset: hold rst_n = 0 → avail_mask = 20'hFFFFF, avail_count = 20, full = 0, alloc_gnt = 0, err_free = 0; release reset with no activity → all outputs unchanged.
- Single requester: alloc_req = 4'b0001 held for 6 cycles → alloc_gnt[0] pulses on alternate cycles with alloc_idx 0, 1, 2; avail_count drops to 17.
- Round-robin: alloc_req = 4'b1111 held → grants 0, 1, 2, 3, 0 on consecutive cycles with idx 0, 1, 2, 3, 4.
- Exhaustion and reuse:
  - Fill all 20 slots → full = 1 and a pending req[2] gets no grant.
  - Free slot 7 → avail_mask bit 7 set next cycle, then req[2] is granted idx 7 and full returns to 1.
- Illegal releases: free_idx = 3 while slot 3 is available → err_free pulse, mask unchanged; free_idx = 25 → err_free pulse.
- Full with simultaneous free plus request: free slot 5 at the edge with req pending → no grant at that edge; grant idx 5 at the next edge. Flush mid-stream → avail_mask all ones, no grant that cycle.
